// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared ALU definitions: 5-bit opcode encoding, flag bit
//               positions and the arbiter FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package alu_arbiter_pkg;

   // ALU opcodes (5 bits). Unlisted encodings produce a zero result.
   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_XOR = 5'b00100;
   localparam logic [4:0] OP_NOT = 5'b00101;
   localparam logic [4:0] OP_SLL = 5'b00110;
   localparam logic [4:0] OP_SRL = 5'b00111;
   localparam logic [4:0] OP_SRA = 5'b01000;
   localparam logic [4:0] OP_INC = 5'b10000;
   localparam logic [4:0] OP_DEC = 5'b10001;

   // Flag vector layout: {N, Z, C, V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Arbiter FSM encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Purely combinational W-bit ALU with {N,Z,C,V} flags.
//               Arithmetic wraps in two's complement. For SUB/DEC the C flag
//               is the borrow out (set when unsigned a < unsigned b).
// Ports       : i_op     [4:0]   opcode (alu_arbiter_pkg::OP_*)
//               i_a, i_b [W-1:0] operands
//               o_result [W-1:0] result
//               o_flags  [3:0]   {N, Z, C, V}
// Revision    : 1.0  initial release
// ============================================================================
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [4:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_result,
   output logic [3:0]   o_flags
);

   localparam int         SHW = (W > 1) ? $clog2(W) : 1;
   localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

   logic [W:0]     w_ext;
   logic [W-1:0]   w_res;
   logic           w_c;
   logic           w_v;
   logic [SHW-1:0] w_sh;

   assign w_sh = i_b[SHW-1:0];

   always_comb begin
      w_ext = '0;
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (i_op)
         OP_ADD: begin
            w_ext = {1'b0, i_a} + {1'b0, i_b};
            w_res = w_ext[W-1:0];
            w_c   = w_ext[W];
            w_v   = (i_a[W-1] == i_b[W-1]) && (w_res[W-1] != i_a[W-1]);
         end
         OP_SUB: begin
            w_ext = {1'b0, i_a} - {1'b0, i_b};
            w_res = w_ext[W-1:0];
            w_c   = w_ext[W];
            w_v   = (i_a[W-1] != i_b[W-1]) && (w_res[W-1] != i_a[W-1]);
         end
         OP_INC: begin
            w_ext = {1'b0, i_a} + ONE;
            w_res = w_ext[W-1:0];
            w_c   = w_ext[W];
            w_v   = !i_a[W-1] && w_res[W-1];
         end
         OP_DEC: begin
            w_ext = {1'b0, i_a} - ONE;
            w_res = w_ext[W-1:0];
            w_c   = w_ext[W];
            w_v   = i_a[W-1] && !w_res[W-1];
         end
         OP_AND: w_res = i_a & i_b;
         OP_OR:  w_res = i_a | i_b;
         OP_XOR: w_res = i_a ^ i_b;
         OP_NOT: w_res = ~i_a;
         OP_SLL: w_res = i_a << w_sh;
         OP_SRL: w_res = i_a >> w_sh;
         OP_SRA: w_res = W'($signed(i_a) >>> w_sh);
         default: w_res = '0;
      endcase
   end

   assign o_result = w_res;
   assign o_flags  = {w_res[W-1], (w_res == '0), w_c, w_v};

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters with round-robin
//               arbitration and a single registered response slot.
//               A grant is issued when the slot is empty or is being drained
//               in the same cycle; the result appears one cycle later.
// Ports       : clk, rst                 clock, async active-high reset
//               reqN_valid/ready         request handshake (N = 0,1)
//               reqN_op/a/b              opcode and operands
//               rsp_valid/ready          response handshake
//               rsp_id                   owner of the held response
//               rsp_result, rsp_flags    registered ALU outputs
//               busy                     response slot occupied
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [4:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [4:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic         busy
);

   logic [0:0]   r_state;
   logic [0:0]   w_state_nxt;
   logic         r_last_grant;
   logic         r_rsp_id;
   logic [W-1:0] r_rsp_result;
   logic [3:0]   r_rsp_flags;

   logic         w_can_grant;
   logic         w_grant0;
   logic         w_grant1;
   logic         w_xfer;
   logic [4:0]   w_alu_op;
   logic [W-1:0] w_alu_a;
   logic [W-1:0] w_alu_b;
   logic [W-1:0] w_alu_result;
   logic [3:0]   w_alu_flags;

   // The slot can accept a new result when empty, or when the held
   // response leaves on this same edge.
   assign w_can_grant = (r_state == ST_IDLE) || rsp_ready;

   // Round-robin: a lone requester always wins; under contention the one
   // that did not win last time goes first. Readies are gated by rst so
   // nothing is accepted while the block is held in reset.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!rst && w_can_grant) begin
         if (req0_valid && (!req1_valid || r_last_grant)) begin
            w_grant0 = 1'b1;
         end else if (req1_valid) begin
            w_grant1 = 1'b1;
         end
      end
   end

   assign w_xfer     = w_grant0 | w_grant1;
   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   // The ALU sees the granted request's operands in the grant cycle.
   assign w_alu_op = w_grant1 ? req1_op : req0_op;
   assign w_alu_a  = w_grant1 ? req1_a  : req0_a;
   assign w_alu_b  = w_grant1 ? req1_b  : req0_b;

   alu #(
      .W (W)
   ) u_alu (
      .i_op     (w_alu_op),
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .o_result (w_alu_result),
      .o_flags  (w_alu_flags)
   );

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready && !w_xfer) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      rsp_valid = (r_state == ST_RESP);
      busy      = (r_state == ST_RESP);
   end

   // Response slot and arbitration history; only a transfer changes them,
   // so the held response stays stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
         r_last_grant <= 1'b1;
      end else if (w_xfer) begin
         r_rsp_id     <= w_grant1;
         r_rsp_result <= w_alu_result;
         r_rsp_flags  <= w_alu_flags;
         r_last_grant <= w_grant1;
      end
   end

   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter. Expected responses are
//               queued by a reference model at grant time and checked by an
//               independent monitor while the DUT presents them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int     W    = 16;
   localparam longint MAXP = (64'sd1 <<< (W-1)) - 1;
   localparam longint MINP = -(64'sd1 <<< (W-1));
   localparam longint MODU = 64'sd1 <<< W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, busy;
   logic [W-1:0] rsp_result;
   logic [3:0]   rsp_flags;

   always #5 clk = ~clk;

   alu_arbiter #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .busy       (busy)
   );

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic [3:0]   flg;
   } rsp_t;

   rsp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic m_busy = 1'b0;   // model: a response is held
   logic m_last = 1'b1;   // model: winner of the previous transfer
   logic g_this = 1'b0;   // model: a grant is happening this cycle

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference ALU from plain integer arithmetic.
   function automatic rsp_t alu_ref(input logic id, input logic [4:0] op,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, ua, sb, ub, s;
      int     sh;
      logic [W-1:0] r;
      logic   c, v;
      rsp_t   t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      sh = int'(ub % W);
      s  = 0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         OP_ADD: begin s = sa + sb; c = (ua + ub) >= MODU; v = (s > MAXP) || (s < MINP); end
         OP_SUB: begin s = sa - sb; c = ua < ub;           v = (s > MAXP) || (s < MINP); end
         OP_INC: begin s = sa + 1;  c = (ua == MODU - 1);  v = (s > MAXP); end
         OP_DEC: begin s = sa - 1;  c = (ua == 0);         v = (s < MINP); end
         OP_SRA: s = sa >>> sh;
         default: s = 0;
      endcase
      r = s[W-1:0];
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOT: r = ~a;
         OP_SLL: r = a << sh;
         OP_SRL: r = a >> sh;
         default: ;
      endcase
      t.id  = id;
      t.res = r;
      t.flg = {r[W-1], (r == '0), c, v};
      return t;
   endfunction

   // Evaluated just before the active edge with inputs stable.
   task automatic model_step();
      logic e0, e1, pref, pref_valid;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!m_busy || rsp_ready) begin
         pref       = ~m_last;
         pref_valid = pref ? req1_valid : req0_valid;
         if (pref_valid) begin
            e0 = ~pref;
            e1 = pref;
         end else begin
            e0 = req0_valid;
            e1 = req1_valid && !req0_valid;
         end
      end
      chk("req_ready", {req1_ready, req0_ready}, {e1, e0});
      g_this = e0 | e1;
      if (e0) q.push_back(alu_ref(1'b0, req0_op, req0_a, req0_b));
      if (e1) q.push_back(alu_ref(1'b1, req1_op, req1_a, req1_b));
      if (e0 | e1) m_last = e1;
      m_busy = (e0 | e1) || (m_busy && !rsp_ready);
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input logic v0, input logic [4:0] o0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0, input logic v1, input logic [4:0] o1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr);
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      rsp_ready  = rr;
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rr);
      step(1'b0, OP_ADD, '0, '0, 1'b0, OP_ADD, '0, '0, rr);
   endtask

   // Asserted mid-cycle to exercise the asynchronous path.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b1;
      #1;
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      q.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      g_this = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: compares whatever the DUT holds against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            int held;
            held = q.size() - int'(g_this);
            chk("rsp_valid", rsp_valid, held > 0);
            chk("busy", busy, held > 0);
            if (rsp_valid && held > 0) begin
               chk("rsp_id", rsp_id, q[0].id);
               chk("rsp_result", rsp_result, q[0].res);
               chk("rsp_flags", rsp_flags, q[0].flg);
               if (rsp_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] ops[12];
      logic       seq[6];
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
              OP_SLL, OP_SRL, OP_SRA, OP_INC, OP_DEC, 5'b11111};
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp_ready  = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single request: INC(-32) -> -31 one cycle later
      step(1'b1, OP_INC, 16'hFFE0, '0, 1'b0, OP_ADD, '0, '0, 1'b1);
      chk("single_valid", rsp_valid, 1);
      chk("single_id", rsp_id, 0);
      chk("single_result", rsp_result, 16'hFFE1);
      idle(1'b1);

      // Contention right after reset: req0 first, then req1
      do_reset();
      step(1'b1, OP_INC, 16'd100, '0, 1'b1, OP_INC, 16'd5, '0, 1'b1);
      chk("cont_id0", rsp_id, 0);
      chk("cont_res0", rsp_result, 101);
      step(1'b1, OP_INC, 16'd100, '0, 1'b1, OP_INC, 16'd5, '0, 1'b1);
      chk("cont_id1", rsp_id, 1);
      chk("cont_res1", rsp_result, 6);
      idle(1'b1);

      // Backpressure: held response of 1 for three cycles
      step(1'b1, OP_INC, '0, '0, 1'b0, OP_ADD, '0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, OP_ADD, 16'd7, 16'd8, 1'b1, OP_SUB, 16'd3, 16'd4, 1'b0);
         chk("bp_result", rsp_result, 1);
         chk("bp_busy", busy, 1);
      end
      idle(1'b1);
      chk("bp_done", rsp_valid, 0);

      // Wrap-around: INC(32767) -> -32768 with overflow
      step(1'b1, OP_INC, 16'h7FFF, '0, 1'b0, OP_ADD, '0, '0, 1'b1);
      chk("wrap_result", rsp_result, 16'h8000);
      chk("wrap_flags", rsp_flags, 4'b1001);
      idle(1'b1);

      // Fairness: continuous contention alternates 0,1,0,1,0,1
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, OP_ADD, rnd_operand(), rnd_operand(),
              1'b1, OP_SUB, rnd_operand(), rnd_operand(), 1'b1);
         seq[i] = rsp_id;
      end
      for (int i = 0; i < 6; i++) chk("fair_id", seq[i], i % 2);
      idle(1'b1);

      // Reset while a req0 response is held; req0 must still win next
      step(1'b1, OP_DEC, 16'd5, '0, 1'b0, OP_ADD, '0, '0, 1'b0);
      chk("mid_valid", rsp_valid, 1);
      do_reset();
      step(1'b1, OP_INC, 16'd1, '0, 1'b1, OP_INC, 16'd2, '0, 1'b1);
      chk("post_rst_id", rsp_id, 0);
      chk("post_rst_result", rsp_result, 2);
      idle(1'b1);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 6, ops[$urandom_range(0, 11)], rnd_operand(), rnd_operand(),
              $urandom_range(0, 9) < 6, ops[$urandom_range(0, 11)], rnd_operand(), rnd_operand(),
              $urandom_range(0, 9) < 7);
      end
      repeat (3) idle(1'b1);
      chk("drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 16, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  5  alu_op encoding.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W  signed operands.
REQ-008 SHALL have port rsp_valid  output  1  response held.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_id  output  1  requester that owns the response.
REQ-011 SHALL have port rsp_result  output  W  registered ALU result.
REQ-012 SHALL have port rsp_flags  output  4  registered ALU flags.
REQ-013 SHALL have port busy  output  1  high when state is RESP.

Function
REQ-014 SHALL share one alu instance between two requesters; a transfer occurs on the rising clk edge when reqN_valid and reqN_ready are both high.
REQ-015 SHALL implement FSM states IDLE and RESP.
REQ-016 SHALL allow a grant when state is IDLE, or when state is RESP and rsp_ready is high (same-cycle drain and refill).
REQ-017 SHALL assert at most one reqN_ready per cycle; reqN_ready SHALL be high only if reqN_valid is high and that requester is granted.
REQ-018 SHALL arbitrate round-robin: if only one requester is valid, grant it; if both are valid, grant the requester not in last_grant.
REQ-019 SHALL update last_grant only on a transfer.
REQ-020 SHALL drive the ALU combinationally from the granted request's op/a/b and capture result, flags and id into the response registers on the grant edge (latency 1: rsp_valid is high the cycle after the transfer).
REQ-021 SHALL transition IDLE->RESP on a grant, RESP->IDLE on rsp_ready with no new grant, and stay in RESP when rsp_ready and a new grant coincide or rsp_ready is low.
REQ-022 SHALL hold rsp_result, rsp_flags and rsp_id stable while rsp_valid is high and rsp_ready is low.
REQ-023 SHALL not depend on requester behaviour after a transfer; a requester may drop valid without penalty.
REQ-024 SHALL treat results as W-bit two's complement wrap-around, exactly as the alu produces them.

Reset
REQ-025 SHALL, on rst high at any time, including mid-response, force state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, busy 0 and last_grant 1 (req0 wins the first contention).
REQ-026 SHALL hold req0_ready and req1_ready low while rst is high.
REQ-027 SHALL discard any pending response on reset, with no replay.

Structure
REQ-028 SHALL take opcode constants (for example OP_INC = 5'b10000) and the FSM state encoding from the shared alu package.
REQ-029 SHALL instantiate the existing alu module as its only sub-module; the arbiter and response register are local logic.

Verification
REQ-030 SHALL cover the single-request case: req0 sends OP_INC with a = -32 -> one cycle later rsp_valid = 1, rsp_id = 0, rsp_result = -31.
REQ-031 SHALL cover contention after reset: both valid with OP_INC, req0 a = 100, req1 a = 5, rsp_ready held high -> responses arrive back-to-back as id 0 with result 101, then id 1 with result 6.
REQ-032 SHALL cover backpressure: rsp_ready low for 3 cycles after a response of 1 for OP_INC with a = 0 -> result stays 1, busy stays 1, both ready signals stay 0, and the response completes when rsp_ready rises.
REQ-033 SHALL cover wrap-around: OP_INC with a = 32767 (W = 16) -> rsp_result = -32768, with overflow flag as the alu defines it.
REQ-034 SHALL cover fairness: both requesters valid continuously for 6 grants -> rsp_id sequence 0,1,0,1,0,1.
REQ-035 SHALL cover reset mid-response: rst asserted while rsp_valid = 1 -> rsp_valid = 0 immediately, and the next contention grants req0.
